// File: rtl/conv_seq_ctrl_pkg.sv
// Shared constants for the convolution sequencer:
// frame geometry, derived widths and FSM encoding.
package conv_seq_ctrl_pkg;

   localparam int IMG_W = 8;
   localparam int K     = 3;
   localparam int OUT_W = IMG_W - K + 1;

   localparam int AW = 6;
   localparam int TW = 4;
   localparam int WW = 6;
   localparam int SW = 2;

   localparam logic [SW-1:0] S_IDLE = 2'd0;
   localparam logic [SW-1:0] S_LOAD = 2'd1;
   localparam logic [SW-1:0] S_CONV = 2'd2;
   localparam logic [SW-1:0] S_DONE = 2'd3;

endpackage

// File: rtl/conv_seq_ctrl_addr_gen.sv
// Window/tap walker: row-major windows, row-major taps,
// one read address per enabled cycle.
module conv_addr_gen
   import conv_seq_ctrl_pkg::*;
#(
   parameter int KS = 3,
   parameter int OW = 6
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          en,
   output logic          step,
   output logic          first,
   output logic          last,
   output logic          frame_end,
   output logic [AW-1:0] addr,
   output logic [TW-1:0] tap,
   output logic [WW-1:0] win
);

   localparam logic [1:0] K_MAX = 2'(KS - 1);
   localparam logic [2:0] O_MAX = 3'(OW - 1);

   logic [2:0] row;
   logic [2:0] col;
   logic [1:0] ky;
   logic [1:0] kx;
   logic [2:0] ay;
   logic [2:0] ax;

   assign step      = en;
   assign first     = tap == '0;
   assign last      = ky == K_MAX && kx == K_MAX;
   assign frame_end = last && row == O_MAX && col == O_MAX;

   // 3-bit sums never exceed 7 since row,col <= 5 and ky,kx <= 2
   assign ay   = row + {1'b0, ky};
   assign ax   = col + {1'b0, kx};
   assign addr = {ay, ax};

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         row <= '0;
         col <= '0;
         ky  <= '0;
         kx  <= '0;
         tap <= '0;
         win <= '0;
      end else if (en) begin
         if (kx == K_MAX) begin
            kx <= '0;
            ky <= (ky == K_MAX) ? 2'd0 : ky + 2'd1;
         end else begin
            kx <= kx + 2'd1;
         end
         tap <= last ? 4'd0 : tap + 4'd1;
         if (last) begin
            win <= frame_end ? 6'd0 : win + 6'd1;
            if (col == O_MAX) begin
               col <= '0;
               row <= (row == O_MAX) ? 3'd0 : row + 3'd1;
            end else begin
               col <= col + 3'd1;
            end
         end
      end
   end

endmodule

// File: rtl/conv_seq_ctrl.sv
// Image load / convolution read sequencer driving an
// external RAM and MAC.
module conv_seq_ctrl
   import conv_seq_ctrl_pkg::AW, conv_seq_ctrl_pkg::TW,
          conv_seq_ctrl_pkg::WW, conv_seq_ctrl_pkg::SW,
          conv_seq_ctrl_pkg::S_IDLE, conv_seq_ctrl_pkg::S_LOAD,
          conv_seq_ctrl_pkg::S_CONV, conv_seq_ctrl_pkg::S_DONE;
#(
   parameter int IMG_W = conv_seq_ctrl_pkg::IMG_W,
   parameter int K     = conv_seq_ctrl_pkg::K,
   parameter int OUT_W = IMG_W - K + 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_st,
   input  logic          ld_valid,
   input  logic [7:0]    ld_data,
   output logic          wr,
   output logic [AW-1:0] address,
   output logic [7:0]    ram_din,
   output logic          mac_en,
   output logic          mac_first,
   output logic [TW-1:0] k_idx,
   output logic          out_st,
   output logic [WW-1:0] out_idx,
   output logic          busy,
   output logic          done
);

   localparam logic [AW:0]   N_PIX    = (AW+1)'(IMG_W * IMG_W);
   localparam logic [WW-1:0] LAST_WIN = WW'(OUT_W * OUT_W - 1);

   logic [SW-1:0] state;
   logic [AW:0]   wr_cnt;
   logic [AW-1:0] addr_q;
   logic          rd_done;

   logic          g_en;
   logic          g_step;
   logic          g_first;
   logic          g_last;
   logic          g_end;
   logic [AW-1:0] g_addr;
   logic [TW-1:0] g_tap;
   logic [WW-1:0] g_win;

   logic          last1;
   logic [WW-1:0] win1;

   assign g_en = state == S_CONV && !rd_done;

   conv_addr_gen #(
      .KS (K),
      .OW (OUT_W)
   ) u_gen (
      .clk       (clk),
      .rst       (rst),
      .clr       (state != S_CONV),
      .en        (g_en),
      .step      (g_step),
      .first     (g_first),
      .last      (g_last),
      .frame_end (g_end),
      .addr      (g_addr),
      .tap       (g_tap),
      .win       (g_win)
   );

   assign address = g_step ? g_addr : addr_q;
   assign busy    = state != S_IDLE;
   assign done    = state == S_DONE;

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= S_IDLE;
         wr      <= 1'b0;
         wr_cnt  <= '0;
         addr_q  <= '0;
         ram_din <= '0;
         rd_done <= 1'b0;
      end else begin
         wr <= 1'b0;
         unique case (state)
            S_IDLE: begin
               if (in_st) begin
                  state  <= S_LOAD;
                  wr_cnt <= '0;
               end
            end
            S_LOAD: begin
               // the full count blocks a 65th write and moves on
               if (wr_cnt == N_PIX) begin
                  state   <= S_CONV;
                  rd_done <= 1'b0;
               end else if (ld_valid) begin
                  wr      <= 1'b1;
                  addr_q  <= wr_cnt[AW-1:0];
                  ram_din <= ld_data;
                  wr_cnt  <= wr_cnt + 1'b1;
               end
            end
            S_CONV: begin
               if (g_step) addr_q <= g_addr;
               if (g_step && g_end) rd_done <= 1'b1;
               if (out_st && out_idx == LAST_WIN) state <= S_DONE;
            end
            S_DONE: state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

   // read data returns one cycle after issue; result one after last tap
   always_ff @(posedge clk) begin
      if (rst) begin
         mac_en    <= 1'b0;
         mac_first <= 1'b0;
         k_idx     <= '0;
         last1     <= 1'b0;
         win1      <= '0;
         out_st    <= 1'b0;
         out_idx   <= '0;
      end else begin
         mac_en    <= g_step;
         mac_first <= g_step && g_first;
         if (g_step) k_idx <= g_tap;
         last1 <= g_step && g_last;
         if (g_step && g_last) win1 <= g_win;
         out_st <= last1;
         if (last1) out_idx <= win1;
      end
   end

endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Scoreboard bench for conv_seq_ctrl with a RAM model
// and a reference MAC.
module tb_conv_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_st;
   logic       ld_valid;
   logic [7:0] ld_data;
   logic       wr;
   logic [5:0] address;
   logic [7:0] ram_din;
   logic       mac_en;
   logic       mac_first;
   logic [3:0] k_idx;
   logic       out_st;
   logic [5:0] out_idx;
   logic       busy;
   logic       done;

   int checks = 0;
   int failures = 0;

   int img [64];
   int kern [9];
   logic signed [7:0] mem [64];
   int wq [$];
   int rq [$];
   int sq [$];

   conv_seq_ctrl dut (
      .clk       (clk),
      .rst       (rst),
      .in_st     (in_st),
      .ld_valid  (ld_valid),
      .ld_data   (ld_data),
      .wr        (wr),
      .address   (address),
      .ram_din   (ram_din),
      .mac_en    (mac_en),
      .mac_first (mac_first),
      .k_idx     (k_idx),
      .out_st    (out_st),
      .out_idx   (out_idx),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic set_kern(input bit ones);
      int kv [9] = '{1, -2, 3, 0, 1, 2, -1, 1, 2};
      for (int i = 0; i < 9; i++) kern[i] = ones ? 1 : kv[i];
   endtask

   // mode 0: data=index, 1: all ones, 2: random
   task automatic do_load(input bit gapped, input int mode,
                          input bit spur);
      int n_drv;
      int n_seen;
      int cyc;
      int e;
      bit v;
      logic [7:0] d;
      wq.delete();
      n_drv = 0;
      n_seen = 0;
      cyc = 0;
      in_st = 1'b1;
      tick;
      in_st = 1'b0;
      while (n_seen < 64 && cyc < 400) begin
         v = gapped ? (cyc % 2 == 0) : 1'b1;
         case (mode)
            0: d = 8'(n_drv);
            1: d = 8'd1;
            default: d = 8'($urandom_range(0, 255));
         endcase
         ld_valid = v;
         ld_data = d;
         in_st = spur && cyc == 21;
         if (v && n_drv < 64) begin
            img[n_drv] = int'($signed(d));
            wq.push_back((n_drv << 8) | int'(d));
            n_drv++;
         end
         tick;
         cyc++;
         checks++;
         if (wr !== v) begin
            failures++;
            $display("FAIL load_wr_strobe cyc=%0d got=%b exp=%b",
                     cyc, wr, v);
         end
         if (wr === 1'b1) begin
            checks++;
            if (wq.size() == 0) begin
               failures++;
               $display("FAIL load_extra_write got addr=%0d exp none",
                        address);
            end else begin
               e = wq.pop_front();
               if ({address, ram_din} !== 14'(e)) begin
                  failures++;
                  $display("FAIL load_write got=%0d/%0h exp=%0d/%0h",
                           address, ram_din, e >> 8, e & 255);
               end
            end
            mem[address] = ram_din;
            n_seen++;
         end
      end
      in_st = 1'b0;
      checks++;
      if (n_seen != 64) begin
         failures++;
         $display("FAIL load_timeout got=%0d writes exp=64", n_seen);
      end
      ld_valid = 1'b1;
      ld_data = 8'hA5;
   endtask

   task automatic run_conv(input int rst_at, input bit spur);
      int acc;
      int prev;
      int r;
      int c;
      int s;
      int e;
      int kk;
      bit em;
      bit eo;
      rq.delete();
      sq.delete();
      for (int w = 0; w < 36; w++) begin
         r = w / 6;
         c = w % 6;
         s = 0;
         for (int k2 = 0; k2 < 9; k2++) begin
            e = (r + k2 / 3) * 8 + c + k2 % 3;
            rq.push_back(e);
            s += img[e] * kern[k2];
         end
         sq.push_back(s);
      end
      acc = 0;
      prev = 0;
      for (int t = 0; t < 330; t++) begin
         in_st = spur && (t == 40 || t == 200);
         tick;
         ld_valid = 1'b0;
         if (t < 324) begin
            e = rq.pop_front();
            checks++;
            if ({wr, address} !== {1'b0, 6'(e)}) begin
               failures++;
               $display("FAIL conv_read t=%0d got wr=%b a=%0d exp a=%0d",
                        t, wr, address, e);
            end
         end
         eo = t >= 10 && t <= 325 && (t - 10) % 9 == 0;
         checks++;
         if (out_st !== eo) begin
            failures++;
            $display("FAIL out_st t=%0d got=%b exp=%b", t, out_st, eo);
         end
         if (eo) begin
            s = sq.pop_front();
            checks++;
            if (out_idx !== 6'((t - 10) / 9) || acc != s) begin
               failures++;
               $display("FAIL window_result t=%0d got=%0d/%0d exp=%0d/%0d",
                        t, out_idx, acc, (t - 10) / 9, s);
            end
         end
         em = t >= 1 && t <= 324;
         kk = (t + 8) % 9;
         checks++;
         if (mac_en !== em) begin
            failures++;
            $display("FAIL mac_en t=%0d got=%b exp=%b", t, mac_en, em);
         end
         if (em) begin
            checks++;
            if ({k_idx, mac_first} !== {4'(kk), kk == 0}) begin
               failures++;
               $display("FAIL mac_tap t=%0d got=%0d/%b exp=%0d/%b",
                        t, k_idx, mac_first, kk, kk == 0);
            end
            if (mac_first) acc = int'(mem[prev]) * kern[k_idx];
            else acc = acc + int'(mem[prev]) * kern[k_idx];
         end
         checks++;
         if (done !== (t == 326)) begin
            failures++;
            $display("FAIL done t=%0d got=%b", t, done);
         end
         checks++;
         if (busy !== (t <= 326)) begin
            failures++;
            $display("FAIL busy t=%0d got=%b", t, busy);
         end
         prev = int'(address);
         if (t == rst_at) begin
            in_st = 1'b0;
            rst = 1'b1;
            tick;
            rst = 1'b0;
            checks++;
            if ({wr, address, ram_din, mac_en, mac_first, k_idx,
                 out_st, out_idx, busy, done} !== '0) begin
               failures++;
               $display("FAIL mid_reset_outputs got wr=%b a=%0d me=%b o=%b b=%b exp all 0",
                        wr, address, mac_en, out_st, busy);
            end
            for (int i = 0; i < 30; i++) begin
               tick;
               checks++;
               if ({wr, mac_en, out_st, done, busy} !== '0) begin
                  failures++;
                  $display("FAIL post_reset_quiet i=%0d got=%b exp=0",
                           i, {wr, mac_en, out_st, done, busy});
               end
            end
            return;
         end
      end
      in_st = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      in_st = 1'b0;
      ld_valid = 1'b0;
      ld_data = '0;
      repeat (3) tick;
      checks++;
      if ({wr, address, ram_din, mac_en, mac_first, k_idx,
           out_st, out_idx, busy, done} !== '0) begin
         failures++;
         $display("FAIL reset_outputs got wr=%b a=%0d d=%0h b=%b exp all 0",
                  wr, address, ram_din, busy);
      end
      rst = 1'b0;
      tick;
      checks++;
      if (busy !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset got busy=%b exp 0", busy);
      end
   endtask

   task automatic test_load;
      set_kern(1'b0);
      do_load(1'b0, 0, 1'b0);
      run_conv(-1, 1'b0);
   endtask

   task automatic test_gapped_pipeline;
      set_kern(1'b1);
      do_load(1'b1, 1, 1'b0);
      run_conv(-1, 1'b0);
   endtask

   task automatic test_spurious_start;
      set_kern(1'b0);
      do_load(1'b0, 2, 1'b1);
      run_conv(-1, 1'b1);
   endtask

   task automatic test_mid_reset;
      set_kern(1'b0);
      do_load(1'b0, 2, 1'b0);
      run_conv(99, 1'b0);
      do_load(1'b0, 0, 1'b0);
      run_conv(-1, 1'b0);
   endtask

   initial begin
      test_reset;
      test_load;
      test_gapped_pipeline;
      test_spurious_start;
      test_mid_reset;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
